// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared ISA constants, FSM encoding and decode bundle
// for the EXE hazard controller.
package exe_hazard_ctrl_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8;
  localparam logic [5:0] OP_SLLV = 6'd9;
  localparam logic [5:0] OP_SRLV = 6'd10;
  localparam logic [5:0] OP_ADDI = 6'd11;
  localparam logic [5:0] OP_ANDI = 6'd12;
  localparam logic [5:0] OP_ORI  = 6'd13;
  localparam logic [5:0] OP_LUI  = 6'd14;
  localparam logic [5:0] OP_LW   = 6'd15;
  localparam logic [5:0] OP_LH   = 6'd16;
  localparam logic [5:0] OP_LD   = 6'd17;
  localparam logic [5:0] OP_SW   = 6'd18;
  localparam logic [5:0] OP_SH   = 6'd19;
  localparam logic [5:0] OP_SD   = 6'd20;
  localparam logic [5:0] OP_BEQ  = 6'd21;
  localparam logic [5:0] OP_BNE  = 6'd22;
  localparam logic [5:0] OP_J    = 6'd23;
  localparam logic [5:0] OP_JAL  = 6'd24;
  localparam logic [5:0] OP_JALR = 6'd25;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_SQUASH   = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_RD,
    DST_RT,
    DST_R31
  } dst_sel_e;

  typedef struct packed {
    logic [4:0] dst;
    logic       dst_valid;
    logic       use_rs;
    logic       use_rt;
    logic       is_load;
    logic       is_halt;
    logic [4:0] rs;
    logic [4:0] rt;
  } reg_use_t;

endpackage

// File: rtl/exe_hazard_ctrl_reg_use_decode.sv
// Register-usage decoder: destination, sources,
// load and halt flags for one instruction word.
module reg_use_decode
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] ir_i,
  output reg_use_t         use_o
);

  logic [5:0] opc;
  logic [4:0] rs, rt, rd;
  dst_sel_e   dsel;
  logic       use_rs, use_rt, is_load, is_halt;
  logic [4:0] dst;
  logic       unused_ok;

  assign opc = ir_i[OPC_MSB:OPC_LSB];
  assign rs  = ir_i[RS_MSB:RS_LSB];
  assign rt  = ir_i[RT_MSB:RT_LSB];
  assign rd  = ir_i[RD_MSB:RD_LSB];
  assign unused_ok = ^ir_i[RD_LSB-1:0];

  // Undefined opcodes fall to default: no sources, no dst.
  always_comb begin
    dsel    = DST_NONE;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV: begin
        dsel   = DST_RD;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_JALR: begin
        dsel   = DST_RD;
        use_rs = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dsel   = DST_RT;
        use_rs = 1'b1;
      end
      OP_LUI: dsel = DST_RT;
      OP_LW, OP_LH, OP_LD: begin
        dsel    = DST_RT;
        use_rs  = 1'b1;
        is_load = 1'b1;
      end
      OP_SW, OP_SH, OP_SD: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: use_rs = 1'b1;
      OP_JAL: dsel = DST_R31;
      OP_HALT: is_halt = 1'b1;
      default: dsel = DST_NONE;
    endcase
  end

  always_comb begin
    dst = 5'd0;
    case (dsel)
      DST_RD:  dst = rd;
      DST_RT:  dst = rt;
      DST_R31: dst = 5'd31;
      default: dst = 5'd0;
    endcase
  end

  assign use_o = '{
    dst:       dst,
    dst_valid: (dsel != DST_NONE) && (dst != 5'd0),
    use_rs:    use_rs,
    use_rt:    use_rt,
    is_load:   is_load,
    is_halt:   is_halt,
    rs:        rs,
    rt:        rt
  };

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Stall/flush sequencer for IF/ID/EXE: load-use,
// memory waits, branch squash, halt, stall counter.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       IR_ID,
  input  logic [WIDTH-1:0]       IR_EXE,
  input  logic [WIDTH-1:0]       IR_MEM,
  input  logic                   IsBranchTaken,
  input  logic                   MemBusy,
  output logic                   StallIF,
  output logic                   StallID,
  output logic                   IsStall,
  output logic                   FlushIF,
  output logic                   FlushID,
  output logic                   Halted,
  output logic [STALL_CNT_W-1:0] StallCount
);

  reg_use_t id_u, ex_u, mem_u;
  logic [1:0] state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic load_use, squash, unused_ok;

  reg_use_decode #(.WIDTH(WIDTH)) u_dec_id (
    .ir_i  (IR_ID),
    .use_o (id_u)
  );

  reg_use_decode #(.WIDTH(WIDTH)) u_dec_ex (
    .ir_i  (IR_EXE),
    .use_o (ex_u)
  );

  reg_use_decode #(.WIDTH(WIDTH)) u_dec_mem (
    .ir_i  (IR_MEM),
    .use_o (mem_u)
  );

  assign unused_ok = ^{id_u, ex_u, mem_u};

  assign load_use = ex_u.is_load && ex_u.dst_valid &&
    ((id_u.use_rs && (id_u.rs == ex_u.dst)) ||
     (id_u.use_rt && (id_u.rt == ex_u.dst)));

  assign squash = (state_q == ST_SQUASH);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (state_q == ST_HALTED || mem_u.is_halt)
      state_d = ST_HALTED;
    else if (MemBusy)
      state_d = ST_MEM_WAIT;
    else if (!squash && IsBranchTaken)
      state_d = ST_SQUASH;
  end

  // Wrong-path branch/load-use are masked while squashing.
  always_comb begin
    StallIF = 1'b0;
    StallID = 1'b0;
    IsStall = 1'b0;
    FlushIF = 1'b0;
    FlushID = 1'b0;
    Halted  = 1'b0;
    priority case (1'b1)
      rst: ;
      (state_q == ST_HALTED): begin
        StallIF = 1'b1;
        StallID = 1'b1;
        IsStall = 1'b1;
        Halted  = 1'b1;
      end
      MemBusy: begin
        StallIF = 1'b1;
        StallID = 1'b1;
        IsStall = 1'b1;
      end
      (!squash && IsBranchTaken): begin
        FlushIF = 1'b1;
        FlushID = 1'b1;
      end
      (!squash && load_use): begin
        StallIF = 1'b1;
        StallID = 1'b1;
        FlushID = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (StallID && !Halted && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign StallCount = cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl with a
// default-width and a 4-bit-counter instance.
module tb_exe_hazard_ctrl;
  import exe_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_ID, IR_EXE, IR_MEM;
  logic        IsBranchTaken, MemBusy;
  logic        StallIF, StallID, IsStall;
  logic        FlushIF, FlushID, Halted;
  logic [15:0] StallCount;
  logic        n_sif, n_sid, n_ist, n_fif, n_fid, n_hlt;
  logic [3:0]  n_cnt;
  logic [5:0]  outs;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign outs = {StallIF, StallID, IsStall, FlushIF, FlushID, Halted};

  exe_hazard_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .IR_ID         (IR_ID),
    .IR_EXE        (IR_EXE),
    .IR_MEM        (IR_MEM),
    .IsBranchTaken (IsBranchTaken),
    .MemBusy       (MemBusy),
    .StallIF       (StallIF),
    .StallID       (StallID),
    .IsStall       (IsStall),
    .FlushIF       (FlushIF),
    .FlushID       (FlushID),
    .Halted        (Halted),
    .StallCount    (StallCount)
  );

  exe_hazard_ctrl #(.STALL_CNT_W(4)) u_dut4 (
    .clk           (clk),
    .rst           (rst),
    .IR_ID         (IR_ID),
    .IR_EXE        (IR_EXE),
    .IR_MEM        (IR_MEM),
    .IsBranchTaken (IsBranchTaken),
    .MemBusy       (MemBusy),
    .StallIF       (n_sif),
    .StallID       (n_sid),
    .IsStall       (n_ist),
    .FlushIF       (n_fif),
    .FlushID       (n_fid),
    .Halted        (n_hlt),
    .StallCount    (n_cnt)
  );

  function automatic logic [31:0] mk(
    input logic [5:0] op,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd
  );
    return {op, rs, rt, rd, 11'd0};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] O_LU  = 6'b110010;
  localparam logic [5:0] O_BR  = 6'b000110;
  localparam logic [5:0] O_MW  = 6'b111000;
  localparam logic [5:0] O_HLT = 6'b111001;

  initial begin
    rst = 1'b1;
    IR_ID = mk(OP_NOP, 0, 0, 0);
    IR_EXE = mk(OP_NOP, 0, 0, 0);
    IR_MEM = mk(OP_NOP, 0, 0, 0);
    IsBranchTaken = 1'b0;
    MemBusy = 1'b0;
    @(negedge clk);
    check("rst_outs", 32'(outs), 32'h0);
    check("rst_cnt", 32'(StallCount), 32'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("idle", 32'(outs), 32'h0);

    tick;
    IR_EXE = mk(OP_LW, 2, 5, 0);
    IR_ID  = mk(OP_ADD, 5, 1, 6);
    @(negedge clk);
    check("lu_rs", 32'(outs), 32'(O_LU));
    tick;
    IR_EXE = mk(OP_NOP, 0, 0, 0);
    @(negedge clk);
    check("lu_clear", 32'(outs), 32'h0);
    check("lu_cnt", 32'(StallCount), 32'd1);

    tick;
    IR_EXE = mk(OP_LH, 3, 7, 0);
    IR_ID  = mk(OP_SW, 4, 7, 0);
    @(negedge clk);
    check("lu_rt", 32'(outs), 32'(O_LU));
    tick;
    IR_EXE = mk(OP_ADD, 1, 2, 5);
    IR_ID  = mk(OP_ADD, 5, 1, 6);
    @(negedge clk);
    check("alu_fwd", 32'(outs), 32'h0);
    check("lu_cnt2", 32'(StallCount), 32'd2);

    tick;
    IR_EXE = mk(OP_LW, 2, 0, 0);
    IR_ID  = mk(OP_ADD, 0, 0, 6);
    @(negedge clk);
    check("lu_r0", 32'(outs), 32'h0);
    tick;
    IR_EXE = mk(OP_LD, 2, 5, 0);
    IR_ID  = mk(OP_LUI, 5, 9, 0);
    @(negedge clk);
    check("lu_lui", 32'(outs), 32'h0);
    tick;
    IR_ID = mk(OP_ADDI, 1, 5, 0);
    @(negedge clk);
    check("lu_addi_rt", 32'(outs), 32'h0);

    tick;
    IR_EXE = mk(OP_LW, 2, 5, 0);
    IR_ID  = mk(OP_ADD, 5, 1, 6);
    IsBranchTaken = 1'b1;
    @(negedge clk);
    check("br_flush", 32'(outs), 32'(O_BR));
    tick;
    @(negedge clk);
    check("br_squash", 32'(outs), 32'h0);
    tick;
    IsBranchTaken = 1'b0;
    IR_EXE = mk(OP_NOP, 0, 0, 0);
    @(negedge clk);
    check("br_run", 32'(outs), 32'h0);
    check("br_cnt", 32'(StallCount), 32'd2);

    for (int i = 0; i < 4; i++) begin
      tick;
      MemBusy = 1'b1;
      @(negedge clk);
      check("mw_stall", 32'(outs), 32'(O_MW));
    end
    tick;
    MemBusy = 1'b0;
    @(negedge clk);
    check("mw_done", 32'(outs), 32'h0);
    check("mw_cnt", 32'(StallCount), 32'd6);

    tick;
    IsBranchTaken = 1'b1;
    @(negedge clk);
    check("sq_br", 32'(outs), 32'(O_BR));
    tick;
    MemBusy = 1'b1;
    @(negedge clk);
    check("sq_mem", 32'(outs), 32'(O_MW));
    tick;
    MemBusy = 1'b0;
    IsBranchTaken = 1'b0;
    @(negedge clk);
    check("sq_done", 32'(outs), 32'h0);
    check("sq_cnt", 32'(StallCount), 32'd7);

    tick;
    IR_MEM = mk(OP_HALT, 0, 0, 0);
    @(negedge clk);
    check("hlt_seen", 32'(outs), 32'h0);
    tick;
    IR_MEM = mk(OP_NOP, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("hlt_hold", 32'(outs), 32'(O_HLT));
      tick;
      MemBusy = (i == 3);
    end
    MemBusy = 1'b0;
    @(negedge clk);
    check("hlt_cnt", 32'(StallCount), 32'd7);
    tick;
    rst = 1'b1;
    @(negedge clk);
    check("rst_hlt", 32'(outs), 32'h0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", 32'(outs), 32'h0);
    check("post_cnt", 32'(StallCount), 32'd0);
    check("post_cnt4", 32'(n_cnt), 32'd0);

    for (int i = 0; i < 20; i++) begin
      tick;
      MemBusy = 1'b1;
    end
    tick;
    MemBusy = 1'b0;
    @(negedge clk);
    check("sat_outs", 32'(outs), 32'h0);
    check("sat_cnt16", 32'(StallCount), 32'd20);
    check("sat_cnt4", 32'(n_cnt), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    $finish;
  end

endmodule
